alta_ram4k_arbiter: RTL and testbench
=====================================

// Module: alta_ram4k_arbiter
// PURPOSE
//  Two-requester round-robin arbiter/sequencer for a single-port alta_ram4k, 256x16 with byte enables.
//  Issues at most one RAM access per cycle and routes read data back to the requester that issued it.
//  Optionally zero-fills the RAM after reset before accepting traffic.
//  Sits between two bus masters (e.g. CPU and DMA) and one alta_ram4k in read_write CLKMODE.
// PARAMETERS
//  DATA_WIDTH     16  requester/RAM data width (16 or 18)
//  ADDR_WIDTH     8   word address width (RAM depth 2**ADDR_WIDTH)
//  BYTE_WIDTH     2   byte-enable width
//  CLEAR_ON_RESET 1   1: run INIT sweep writing 0 to every word after reset; 0: go straight to RUN
// PORTS
//  Clk           in   1           single clock, drives RAM Clk0 too
//  Reset         in   1           synchronous, active-high
//  ReqValidN     in   1           (N=0,1) requester N has a request
//  ReqReadyN     out  1           request N accepted this cycle
//  ReqWeN        in   1           1=write, 0=read
//  ReqAddrN      in   ADDR_WIDTH  word address
//  ReqDataN      in   DATA_WIDTH  write data
//  ReqByteEnN    in   BYTE_WIDTH  write byte enables (ignored for reads)
//  RspValidN     out  1           one-cycle pulse: RspDataN valid for requester N
//  RspDataN      out  DATA_WIDTH  read data
//  Busy          out  1           1 while in INIT
//  RamAddress    out  ADDR_WIDTH  to alta_ram4k AddressA
//  RamDataIn     out  DATA_WIDTH  to DataInA
//  RamByteEn     out  BYTE_WIDTH  to ByteEnA
//  RamWeRen      out  1           to WeRenA (1=write)
//  RamClkEn      out  1           to ClkEn0; 1 only in a cycle carrying an access
//  RamDataOut    in   DATA_WIDTH  from DataOutA
// BEHAVIOUR
//  - States: INIT, RUN. Reset -> INIT if CLEAR_ON_RESET else RUN. Reset in any state restarts there.
//  - Reset values: ReqReady*=0, RspValid*=0, RspData*=0, RamClkEn=0, RamWeRen=0, Ram* buses=0,
//    Busy=CLEAR_ON_RESET, rr pointer=0 (requester 0 favoured), clear counter=0.
//  - INIT: each cycle RamClkEn=1, RamWeRen=1, RamByteEn=all 1, RamDataIn=0, RamAddress=counter;
//    counter++; after address 2**ADDR_WIDTH-1 -> RUN next cycle, Busy=0. ReqReady*=0 throughout.
//  - RUN grant (combinational ReqReady, same cycle): only one valid -> grant it; both valid -> grant
//    requester named by rr pointer; after a granted cycle pointer = ~granted. No request: pointer holds.
//  - Granted cycle drives Ram* from the winner combinationally; RamClkEn=1. No grant: RamClkEn=0.
//  - Reads: RAM registered; RspValidN/RspDataN asserted exactly READ_LAT cycles after grant cycle
//    (READ_LAT=1 base). A tag pipeline of depth READ_LAT (valid+requester id) steers data.
//    Back-to-back reads give back-to-back responses, no bubbles. Writes produce no response.
//  - Requesters must accept responses unconditionally (no RspReady).
//  - Write then read same address in consecutive grants: read returns new data (RAM normal mode).
//  - ReqByteEn=0 on a write: access issued, memory unchanged.
//  - Reset with reads in flight: tag pipeline cleared, those responses are dropped.
// CONFIGURATION
//  RAM4K_ARB_OUTREG_EN defined: RAM instantiated with PORTA_OUTREG="yes"; READ_LAT=2; tag pipeline
//    depth 2; the output-register stage is clocked every cycle (RamClkEn not gated for it).
//  Undefined: PORTA_OUTREG="no"; READ_LAT=1.
// TESTING
//  1 Reset, CLEAR_ON_RESET=1 -> Busy=1 for 256 cycles, ReqReady*=0; any later read returns 0x0000.
//  2 Req0 write addr 0x12 data 0xBEEF be=11, then read 0x12 -> RspValid0 READ_LAT cycles after
//    grant, RspData0=0xBEEF; RspValid1 stays 0.
//  3 Both valid reads every cycle for 8 cycles -> grants alternate 0,1,0,1...; responses alternate
//    with no gaps; each carries its own address data.
//  4 Write 0x1234 to 0x40, then write 0xAB00 be=10 to 0x40, read -> 0xAB34.
//  5 Req1 only, valid 5 cycles -> granted every cycle; then both valid -> req0 granted first.
//  6 Reset asserted mid-INIT (counter=0x80) and with 2 reads in flight -> no RspValid; INIT restarts
//    at 0x00. Run 2-3 with RAM4K_ARB_OUTREG_EN both defined and undefined.

Source files
------------

// File: rtl/alta_ram4k_arbiter.sv
// Two-requester round-robin front end for one single-port alta_ram4k (read_write mode).
// Define RAM4K_ARB_OUTREG_EN when the RAM is built with PORTA_OUTREG="yes" (read latency 2).
module alta_ram4k_arbiter #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 8,
  parameter int BYTE_WIDTH     = 2,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  ReqValid0,
  output logic                  ReqReady0,
  input  logic                  ReqWe0,
  input  logic [ADDR_WIDTH-1:0] ReqAddr0,
  input  logic [DATA_WIDTH-1:0] ReqData0,
  input  logic [BYTE_WIDTH-1:0] ReqByteEn0,
  input  logic                  ReqValid1,
  output logic                  ReqReady1,
  input  logic                  ReqWe1,
  input  logic [ADDR_WIDTH-1:0] ReqAddr1,
  input  logic [DATA_WIDTH-1:0] ReqData1,
  input  logic [BYTE_WIDTH-1:0] ReqByteEn1,
  output logic                  RspValid0,
  output logic [DATA_WIDTH-1:0] RspData0,
  output logic                  RspValid1,
  output logic [DATA_WIDTH-1:0] RspData1,
  output logic                  Busy,
  output logic [ADDR_WIDTH-1:0] RamAddress,
  output logic [DATA_WIDTH-1:0] RamDataIn,
  output logic [BYTE_WIDTH-1:0] RamByteEn,
  output logic                  RamWeRen,
  output logic                  RamClkEn,
  input  logic [DATA_WIDTH-1:0] RamDataOut
);

`ifdef RAM4K_ARB_OUTREG_EN
  localparam int READ_LAT = 2;
`else
  localparam int READ_LAT = 1;
`endif

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic                    rr_q, rr_d;
  logic [READ_LAT-1:0]     tag_vld_q, tag_vld_d;
  logic [READ_LAT-1:0]     tag_id_q, tag_id_d;
  logic                    gnt0, gnt1, rd_issue, rsp_vld;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    rr_d       = rr_q;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    RamAddress = '0;
    RamDataIn  = '0;
    RamByteEn  = '0;
    RamWeRen   = 1'b0;
    RamClkEn   = 1'b0;
    unique case (state_q)
      S_INIT: begin
        RamClkEn   = 1'b1;
        RamWeRen   = 1'b1;
        RamByteEn  = '1;
        RamAddress = cnt_q;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = S_RUN;
          busy_d  = 1'b0;
        end
      end
      S_RUN: begin
        // rr_q names the requester that wins a tie
        gnt0 = ReqValid0 & (~ReqValid1 | ~rr_q);
        gnt1 = ReqValid1 & (~ReqValid0 |  rr_q);
        if (gnt0) begin
          RamClkEn   = 1'b1;
          RamWeRen   = ReqWe0;
          RamAddress = ReqAddr0;
          RamDataIn  = ReqData0;
          RamByteEn  = ReqByteEn0;
          rr_d       = 1'b1;
        end else if (gnt1) begin
          RamClkEn   = 1'b1;
          RamWeRen   = ReqWe1;
          RamAddress = ReqAddr1;
          RamDataIn  = ReqData1;
          RamByteEn  = ReqByteEn1;
          rr_d       = 1'b0;
        end
      end
      default: ;
    endcase
    if (Reset) begin
      gnt0       = 1'b0;
      gnt1       = 1'b0;
      RamClkEn   = 1'b0;
      RamWeRen   = 1'b0;
      RamAddress = '0;
      RamDataIn  = '0;
      RamByteEn  = '0;
    end
    rd_issue     = (gnt0 & ~ReqWe0) | (gnt1 & ~ReqWe1);
    tag_vld_d    = '0;
    tag_id_d     = '0;
    tag_vld_d[0] = rd_issue;
    tag_id_d[0]  = gnt1;
    for (int i = 1; i < READ_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? S_INIT : S_RUN;
      cnt_q     <= '0;
      busy_q    <= (CLEAR_ON_RESET != 0);
      rr_q      <= 1'b0;
      tag_vld_q <= '0;
      tag_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      rr_q      <= rr_d;
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
    end
  end

  // Response is the RAM output steered by the oldest tag; suppressed while in reset
  assign rsp_vld   = tag_vld_q[READ_LAT-1] & ~Reset;
  assign RspValid0 = rsp_vld & ~tag_id_q[READ_LAT-1];
  assign RspValid1 = rsp_vld &  tag_id_q[READ_LAT-1];
  assign RspData0  = RspValid0 ? RamDataOut : '0;
  assign RspData1  = RspValid1 ? RamDataOut : '0;
  assign ReqReady0 = gnt0;
  assign ReqReady1 = gnt1;
  assign Busy      = busy_q;

endmodule

// File: tb/tb_alta_ram4k_arbiter.sv
// Scoreboard bench for alta_ram4k_arbiter with a behavioural alta_ram4k port-A model.
// Honours RAM4K_ARB_OUTREG_EN (adds the RAM output register, latency 2).
module tb_alta_ram4k_arbiter;

`ifdef RAM4K_ARB_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        Clk = 1'b0;
  logic        Reset;
  logic        ReqValid0, ReqReady0, ReqWe0, ReqValid1, ReqReady1, ReqWe1;
  logic [7:0]  ReqAddr0, ReqAddr1;
  logic [15:0] ReqData0, ReqData1;
  logic [1:0]  ReqByteEn0, ReqByteEn1;
  logic        RspValid0, RspValid1, Busy, RamWeRen, RamClkEn;
  logic [15:0] RspData0, RspData1, RamDataIn, RamDataOut;
  logic [7:0]  RamAddress;
  logic [1:0]  RamByteEn;

  always #5 Clk = ~Clk;

  alta_ram4k_arbiter dut (
    .Clk(Clk), .Reset(Reset),
    .ReqValid0(ReqValid0), .ReqReady0(ReqReady0), .ReqWe0(ReqWe0), .ReqAddr0(ReqAddr0),
    .ReqData0(ReqData0), .ReqByteEn0(ReqByteEn0),
    .ReqValid1(ReqValid1), .ReqReady1(ReqReady1), .ReqWe1(ReqWe1), .ReqAddr1(ReqAddr1),
    .ReqData1(ReqData1), .ReqByteEn1(ReqByteEn1),
    .RspValid0(RspValid0), .RspData0(RspData0), .RspValid1(RspValid1), .RspData1(RspData1),
    .Busy(Busy), .RamAddress(RamAddress), .RamDataIn(RamDataIn), .RamByteEn(RamByteEn),
    .RamWeRen(RamWeRen), .RamClkEn(RamClkEn), .RamDataOut(RamDataOut)
  );

  // RAM model; tb_fill preloads garbage so the clear sweep is observable
  logic [15:0] mem [256];
  logic [15:0] ram_q, ram_q2;
  logic        tb_fill;
  always @(posedge Clk) begin
    if (tb_fill) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'hDEAD;
    end else if (RamClkEn) begin
      if (RamWeRen) begin
        if (RamByteEn[0]) mem[RamAddress][7:0]  <= RamDataIn[7:0];
        if (RamByteEn[1]) mem[RamAddress][15:8] <= RamDataIn[15:8];
      end else begin
        ram_q <= mem[RamAddress];
      end
    end
    ram_q2 <= ram_q;
  end
  assign RamDataOut = (LAT == 2) ? ram_q2 : ram_q;

  int n_chk = 0, n_err = 0, cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct { logic id; logic [15:0] data; int cyc; } sb_t;
  sb_t         sbq[$];
  sb_t         e;
  logic [15:0] model_mem [256];
  logic        model_rr;

  always @(posedge Clk) begin
    #2;
    if (RspValid0 || RspValid1) begin
      if (sbq.size() == 0) chk("rsp_spurious", {RspValid1, RspValid0}, 2'b00);
      else begin
        e = sbq.pop_front();
        chk("rsp_who", {RspValid1, RspValid0}, e.id ? 2'b10 : 2'b01);
        chk("rsp_lat", cyc - e.cyc, LAT);
        chk("rsp_data", e.id ? RspData1 : RspData0, e.data);
      end
    end
  end

  // One cycle of stimulus; grant/RAM bus checked against the round-robin model
  task automatic drive(input logic v0, input logic we0, input logic [7:0] a0, input logic [15:0] d0,
                       input logic [1:0] be0, input logic v1, input logic we1, input logic [7:0] a1,
                       input logic [15:0] d1, input logic [1:0] be1);
    logic eg0, eg1, we;
    logic [7:0] a;
    logic [15:0] d;
    logic [1:0] be;
    @(negedge Clk);
    ReqValid0 = v0; ReqWe0 = we0; ReqAddr0 = a0; ReqData0 = d0; ReqByteEn0 = be0;
    ReqValid1 = v1; ReqWe1 = we1; ReqAddr1 = a1; ReqData1 = d1; ReqByteEn1 = be1;
    #1;
    eg0 = v0 & (~v1 | ~model_rr);
    eg1 = v1 & (~v0 | model_rr);
    chk("gnt", {ReqReady1, ReqReady0}, {eg1, eg0});
    chk("ram_en", RamClkEn, eg0 | eg1);
    if (eg0 | eg1) begin
      we = eg0 ? we0 : we1; a = eg0 ? a0 : a1; d = eg0 ? d0 : d1; be = eg0 ? be0 : be1;
      chk("ram_bus", {RamWeRen, RamAddress}, {we, a});
      if (we) begin
        chk("ram_wr", {RamByteEn, RamDataIn}, {be, d});
        if (be[0]) model_mem[a][7:0]  = d[7:0];
        if (be[1]) model_mem[a][15:8] = d[15:8];
      end else begin
        sbq.push_back('{id: eg1, data: model_mem[a], cyc: cyc});
      end
      model_rr = eg0;
    end
  endtask

  task automatic wr0(input logic [7:0] a, input logic [15:0] d, input logic [1:0] be);
    drive(1, 1, a, d, be, 0, 0, 0, 0, 0);
  endtask
  task automatic rd0(input logic [7:0] a); drive(1, 0, a, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic rd1(input logic [7:0] a); drive(0, 0, 0, 0, 0, 1, 0, a, 0, 0); endtask
  task automatic idle(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask

  // Releases reset and follows the clear sweep; abort_at >= 0 re-asserts reset at that count
  task automatic run_init(input int abort_at);
    int n;
    n = 0;
    @(negedge Clk);
    Reset = 0; ReqValid0 = 1; ReqValid1 = 1; ReqWe0 = 0; ReqWe1 = 0;
    while (n < 600) begin
      #1;
      if (!Busy) break;
      chk("init_rdy", {ReqReady1, ReqReady0}, 2'b00);
      chk("init_ram", {RamClkEn, RamWeRen, RamByteEn, RamDataIn}, {4'b1111, 16'h0});
      chk("init_addr", RamAddress, n[7:0]);
      if (n == abort_at) begin
        Reset = 1; ReqValid0 = 0; ReqValid1 = 0;
        return;
      end
      n++;
      @(negedge Clk);
    end
    ReqValid0 = 0; ReqValid1 = 0;
    chk("init_len", n, 256);
    for (int i = 0; i < 256; i++) model_mem[i] = 16'h0;
    model_rr = 0;
  endtask

  initial begin
    Reset = 1; tb_fill = 1; model_rr = 0;
    ReqValid0 = 1; ReqWe0 = 0; ReqAddr0 = 0; ReqData0 = 0; ReqByteEn0 = 0;
    ReqValid1 = 0; ReqWe1 = 0; ReqAddr1 = 0; ReqData1 = 0; ReqByteEn1 = 0;
    repeat (2) @(negedge Clk);
    #1;
    chk("rst_rdy", {ReqReady1, ReqReady0}, 2'b00);
    chk("rst_rsp", {RspValid1, RspValid0, RspData0, RspData1}, 34'h0);
    chk("rst_ram", {RamClkEn, RamWeRen, RamAddress, RamByteEn, RamDataIn}, 28'h0);
    chk("rst_busy", Busy, 1'b1);
    tb_fill = 0; ReqValid0 = 0;
    run_init(-1);

    // cleared memory reads back zero, both requesters
    rd0(8'h00); rd1(8'hFF); rd0(8'h80); idle();
    // write then read same word
    wr0(8'h12, 16'hBEEF, 2'b11); rd0(8'h12); idle(); idle();
    // tagged contents for the alternating read burst
    for (int i = 0; i < 16; i++) drive(0, 0, 0, 0, 0, 1, 1, 8'h20 + 8'(i), 16'hA500 + 16'(i * 17), 2'b11);
    for (int i = 0; i < 8; i++) drive(1, 0, 8'h20 + 8'(i), 0, 0, 1, 0, 8'h28 + 8'(i), 0, 0);
    idle(); idle();
    // byte-enable merge and a write with no lanes enabled
    wr0(8'h40, 16'h1234, 2'b11); wr0(8'h40, 16'hAB00, 2'b10); rd0(8'h40);
    wr0(8'h40, 16'hFFFF, 2'b00); rd0(8'h40); idle(); idle();
    // requester 1 alone, then a tie
    for (int i = 0; i < 5; i++) rd1(8'h20 + 8'(i));
    drive(1, 0, 8'h12, 0, 0, 1, 0, 8'h40, 0, 0);
    drive(1, 0, 8'h12, 0, 0, 1, 0, 8'h40, 0, 0);
    idle(); idle();
    // reset with reads in flight, then reset mid-sweep
    rd0(8'h12); rd1(8'h40);
    @(posedge Clk); #1;
    Reset = 1; ReqValid0 = 0; ReqValid1 = 0;
    sbq.delete();
    @(negedge Clk); #1;
    chk("rst_drop", {RspValid1, RspValid0}, 2'b00);
    run_init(8'h80);
    run_init(-1);
    // pointer back to requester 0, memory re-cleared
    drive(1, 0, 8'h12, 0, 0, 1, 0, 8'h40, 0, 0);
    drive(1, 0, 8'h12, 0, 0, 1, 0, 8'h40, 0, 0);
    for (int i = 0; i < 10 && sbq.size() != 0; i++) idle();
    chk("drain", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
